// File: rtl/me_search_sched.sv
`default_nettype none
// ============================================================================
// Module   : me_search_sched
// Purpose  : Search-window scheduler for the integer motion-estimation core.
//            Walks the candidate columns of one block's search window, issues
//            one column request per accepted handshake to the SAD array, and
//            reduces the per-column minima returned by the compare tree to a
//            single best motion vector and SAD, presented on a valid/ready
//            output.
// Optional : ME_EARLY_TERM_EN - when defined, a zero SAD terminates the
//            search early (no further requests; outstanding returns drained).
// Ports    :
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   start          in   one-cycle search request, sampled only in IDLE
//   busy           out  high in every state except IDLE
//   col_req_valid  out  column request valid
//   col_req_ready  in   SAD array accepts the request
//   col_idx        out  column being requested
//   cmp_valid      in   compare-tree result valid (returns in issue order)
//   sad_cmp        in   column minimum SAD
//   motion_vec_y   in   row of the column minimum
//   res_valid      out  final result valid
//   res_ready      in   consumer accepts the result
//   best_sad       out  overall minimum SAD
//   best_mv_x      out  column of the minimum
//   best_mv_y      out  row of the minimum
// Revision : 1.0 - initial release
// ============================================================================
module me_search_sched #(
  parameter int SAD_W   = 14,
  parameter int MVY_W   = 4,
  parameter int MVX_W   = 4,
  parameter int NUM_COL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             col_req_valid,
  input  logic             col_req_ready,
  output logic [MVX_W-1:0] col_idx,
  input  logic             cmp_valid,
  input  logic [SAD_W-1:0] sad_cmp,
  input  logic [MVY_W-1:0] motion_vec_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SAD_W-1:0] best_sad,
  output logic [MVX_W-1:0] best_mv_x,
  output logic [MVY_W-1:0] best_mv_y
);

  // One extra counter bit so NUM_COL == 2**MVX_W can be represented.
  localparam int                 c_cnt_w    = MVX_W + 1;
  localparam logic [c_cnt_w-1:0] c_last_col = c_cnt_w'(NUM_COL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [c_cnt_w-1:0] r_iss_cnt;
  logic [c_cnt_w-1:0] r_ret_cnt;
  logic [c_cnt_w-1:0] w_ret_cnt_nxt;

  logic               r_best_vld;
  logic [SAD_W-1:0]   r_best_sad;
  logic [MVX_W-1:0]   r_best_mv_x;
  logic [MVY_W-1:0]   r_best_mv_y;

  logic               w_start_fire;
  logic               w_req_fire;
  logic               w_ret_fire;
  logic               w_best_upd;
  logic               w_term_hit;
  logic               w_upd_ok;

  assign w_start_fire  = (r_state == S_IDLE) && start;
  assign w_req_fire    = (r_state == S_ISSUE) && col_req_ready;
  // Results are only meaningful while a search is in flight.
  assign w_ret_fire    = cmp_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_ret_cnt_nxt = r_ret_cnt + c_cnt_w'(w_ret_fire);

`ifdef ME_EARLY_TERM_EN
  // Once a zero SAD is seen the best is a perfect match and is frozen.
  logic r_term;

  assign w_term_hit = w_ret_fire && (sad_cmp == '0);
  assign w_upd_ok   = !r_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_term <= 1'b0;
    end else if (w_start_fire) begin
      r_term <= 1'b0;
    end else if (w_term_hit) begin
      r_term <= 1'b1;
    end
  end
`else
  assign w_term_hit = 1'b0;
  assign w_upd_ok   = 1'b1;
`endif

  // Strict less-than keeps the earlier (smaller x) column on a tie.
  assign w_best_upd = w_ret_fire && w_upd_ok &&
                      (!r_best_vld || (sad_cmp < r_best_sad));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs (all outputs decode from registers only)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    busy          = 1'b0;
    col_req_valid = 1'b0;
    col_idx       = '0;
    res_valid     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy          = 1'b1;
        col_req_valid = 1'b1;
        col_idx       = r_iss_cnt[MVX_W-1:0];
        if ((w_req_fire && (r_iss_cnt == c_last_col)) || w_term_hit) begin
          w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
        // Compare against the post-edge return count so that the edge that
        // absorbs the last result is also the one that enters DONE.
        if (w_ret_cnt_nxt == r_iss_cnt) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Issue / return counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
    end else if (w_start_fire) begin
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (w_req_fire) begin
        r_iss_cnt <= r_iss_cnt + c_cnt_w'(1);
      end
      r_ret_cnt <= w_ret_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Best-candidate registers; the column tag is the return count since
  // results come back in issue order.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best_vld  <= 1'b0;
      r_best_sad  <= '0;
      r_best_mv_x <= '0;
      r_best_mv_y <= '0;
    end else if (w_start_fire) begin
      r_best_vld <= 1'b0;
    end else if (w_best_upd) begin
      r_best_vld  <= 1'b1;
      r_best_sad  <= sad_cmp;
      r_best_mv_x <= r_ret_cnt[MVX_W-1:0];
      r_best_mv_y <= motion_vec_y;
    end
  end

  assign best_sad  = r_best_sad;
  assign best_mv_x = r_best_mv_x;
  assign best_mv_y = r_best_mv_y;

endmodule
`default_nettype wire
